console_rx_fifo: RTL and testbench

- Receive-side buffer between the console simpleuart and the CPU core.
- Polls the UART data register and drains each received byte into an internal FIFO, pulsing the UART read strobe once per byte.
- Presents the head byte to the CPU's non-blocking console-read instruction (B3), so bytes arriving while the CPU is busy (DELAY, UART write) are not lost.
- When the FIFO is empty, the CPU side reads 0, matching the existing "0 byte means no data" convention.

---
 rtl/console_rx_fifo.sv | 57 +++++
 tb/tb_console_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/console_rx_fifo.sv
// console_rx_fifo: drains simpleuart RX bytes into a FIFO that the CPU pops
// through its non-blocking console-read; an empty FIFO reads as 0.
module console_rx_fifo #(
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [31:0] EMPTY_CODE = 32'hFFFFFFFF,
   parameter int          HOLDOFF    = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [31:0]           uart_dat_do,
   output logic                  uart_dat_re,
   input  logic                  cpu_re,
   output logic [31:0]           cpu_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  clear_ovf
);
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   typedef enum logic {IDLE, WAIT} state_t;
   state_t                r_state;
   logic [3:0]            r_hold;
   logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_ovf;
   logic [7:0]            r_mem [1 << DEPTH_LOG2];
   logic                  w_cap, w_pop, w_push;
   // the strobe is qualified by resetn so it drops at once when reset asserts
   assign w_cap       = resetn && r_state == IDLE && uart_dat_do != EMPTY_CODE;
   assign w_pop       = cpu_re && r_count != '0;
   assign w_push      = w_cap && (!full || w_pop);
   assign uart_dat_re = w_cap;
   assign empty       = r_count == '0;
   assign full        = r_count == FULL_CNT;
   assign count       = r_count;
   assign overflow    = r_ovf;
   assign cpu_data    = empty ? 32'h0 : {24'b0, r_mem[r_rptr]};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_state <= IDLE;
         r_hold  <= 4'd0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= r_state == IDLE ? (w_cap ? WAIT : IDLE) : (r_hold == 4'd1 ? IDLE : WAIT);
         r_hold  <= r_state == IDLE ? (w_cap ? 4'(HOLDOFF) : r_hold) : r_hold - 4'd1;
         r_wptr  <= w_push ? r_wptr + DEPTH_LOG2'(1) : r_wptr;
         r_rptr  <= w_pop ? r_rptr + DEPTH_LOG2'(1) : r_rptr;
         r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
         r_ovf   <= (w_cap && !w_push) ? 1'b1 : (clear_ovf ? 1'b0 : r_ovf);
      end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= uart_dat_do[7:0];
endmodule

// File: tb/tb_console_rx_fifo.sv
// tb_console_rx_fifo: directed checks of capture, holdoff, FIFO order,
// full/empty corner cases, overflow and asynchronous reset.
module tb_console_rx_fifo;
   localparam logic [31:0] EMPTY = 32'hFFFFFFFF;
   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] uart_dat_do;
   logic        uart_dat_re;
   logic        cpu_re;
   logic [31:0] cpu_data;
   logic        empty, full, overflow, clear_ovf;
   logic [4:0]  count;
   int          errors = 0;
   int          checks = 0;

   console_rx_fifo dut (
      .clk(clk), .resetn(resetn), .uart_dat_do(uart_dat_do), .uart_dat_re(uart_dat_re),
      .cpu_re(cpu_re), .cpu_data(cpu_data), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      uart_dat_do = {24'b0, b};
      #1;
      chk("push_re", uart_dat_re, 1);
      tick();
      uart_dat_do = EMPTY;
      tick();
      tick();
   endtask

   task automatic pop(input logic [7:0] b);
      cpu_re = 1'b1;
      #1;
      chk("pop_data", cpu_data, {24'b0, b});
      tick();
      cpu_re = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; uart_dat_do = 32'h41; cpu_re = 1'b0; clear_ovf = 1'b0;
      #2;
      chk("rst_re", uart_dat_re, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", cpu_data, 0);
      uart_dat_do = EMPTY;
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("idle_re", uart_dat_re, 0);
         tick();
      end
      chk("idle_empty", empty, 1);
      chk("idle_data", cpu_data, 0);
      chk("idle_count", count, 0);
      // single byte
      uart_dat_do = 32'h41;
      #1;
      chk("b41_re", uart_dat_re, 1);
      tick();
      uart_dat_do = EMPTY;
      #1;
      chk("b41_re_low", uart_dat_re, 0);
      chk("b41_count", count, 1);
      chk("b41_data", cpu_data, 32'h41);
      tick();
      tick();
      pop(8'h41);
      #1;
      chk("b41_pop_count", count, 0);
      chk("b41_pop_data", cpu_data, 0);
      // fill, overflow, drain
      for (int i = 1; i <= 16; i++) push(8'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      chk("fill_ovf0", overflow, 0);
      push(8'h11);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      for (int i = 1; i <= 16; i++) pop(8'(i));
      #1;
      chk("drain_empty", empty, 1);
      chk("drain_data", cpu_data, 0);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      #1;
      chk("ovf_clr", overflow, 0);
      // push and pop together at full
      for (int i = 1; i <= 16; i++) push(8'(i));
      uart_dat_do = 32'h55;
      cpu_re = 1'b1;
      #1;
      chk("pp_re", uart_dat_re, 1);
      chk("pp_pop", cpu_data, 32'h01);
      tick();
      uart_dat_do = EMPTY;
      cpu_re = 1'b0;
      #1;
      chk("pp_count", count, 16);
      chk("pp_ovf", overflow, 0);
      chk("pp_head", cpu_data, 32'h02);
      tick();
      tick();
      for (int i = 2; i <= 16; i++) pop(8'(i));
      pop(8'h55);
      // push and pop together at empty
      uart_dat_do = 32'h33;
      cpu_re = 1'b1;
      #1;
      chk("pe_data", cpu_data, 0);
      tick();
      uart_dat_do = EMPTY;
      cpu_re = 1'b0;
      #1;
      chk("pe_count", count, 1);
      chk("pe_head", cpu_data, 32'h33);
      tick();
      tick();
      pop(8'h33);
      // holdoff spacing with a constant byte
      uart_dat_do = 32'h7A;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("hold_re", uart_dat_re, (i % 3 == 0) ? 1 : 0);
         tick();
      end
      uart_dat_do = EMPTY;
      tick();
      tick();
      chk("hold_count", count, 4);
      for (int i = 0; i < 4; i++) pop(8'h7A);
      // pop while empty
      cpu_re = 1'b1;
      tick();
      cpu_re = 1'b0;
      #1;
      chk("pop_empty_count", count, 0);
      chk("pop_empty_flag", empty, 1);
      chk("pop_empty_ovf", overflow, 0);
      // discard wins over clear_ovf
      for (int i = 1; i <= 16; i++) push(8'(i + 8'h80));
      push(8'h11);
      chk("ovf2_set", overflow, 1);
      uart_dat_do = 32'h22;
      clear_ovf = 1'b1;
      #1;
      chk("clr_disc_re", uart_dat_re, 1);
      tick();
      uart_dat_do = EMPTY;
      clear_ovf = 1'b0;
      #1;
      chk("clr_disc_ovf", overflow, 1);
      chk("clr_disc_head", cpu_data, 32'h81);
      tick();
      tick();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      #1;
      chk("clr_only_ovf", overflow, 0);
      // reset during WAIT
      uart_dat_do = 32'h99;
      tick();
      uart_dat_do = EMPTY;
      #1;
      chk("wait_ovf", overflow, 1);
      resetn = 1'b0;
      #1;
      chk("arst_re", uart_dat_re, 0);
      chk("arst_count", count, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_data", cpu_data, 0);
      uart_dat_do = 32'h99;
      #1;
      chk("arst_re_held", uart_dat_re, 0);
      uart_dat_do = EMPTY;
      tick();
      resetn = 1'b1;
      tick();
      push(8'h5A);
      chk("post_rst_count", count, 1);
      chk("post_rst_data", cpu_data, 32'h5A);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
